// File: rtl/lsu_pkg.sv
// Shared size codes, FSM states and word width for the load/store unit.
// Included by both the lane aligner and the top-level controller.
package lsu_pkg;
  localparam int WORD_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR,
    RESP
  } state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
// Purely combinational; no latency and no flow control.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] i_rd_word,
  input  logic [1:0]        i_addr_lo,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_load_data,
  output logic [WORD_W-1:0] o_merged_word
);

  function automatic logic [WORD_W-1:0] load_extend(
    input logic [WORD_W-1:0] word,
    input logic [1:0]        lo,
    input logic [1:0]        size,
    input logic              uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = word[{lo[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: load_extend = {{24{~uns & b[7]}}, b};
      SZ_HALF: load_extend = {{16{~uns & h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] store_merge(
    input logic [WORD_W-1:0] word,
    input logic [WORD_W-1:0] wdata,
    input logic [1:0]        lo,
    input logic [1:0]        size
  );
    store_merge = word;
    case (size)
      SZ_BYTE: store_merge[{lo, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: store_merge[{lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_merge = wdata;
    endcase
  endfunction

  assign o_load_data   = load_extend(i_rd_word, i_addr_lo, i_size, i_unsigned);
  assign o_merged_word = store_merge(i_rd_word, i_wdata, i_addr_lo, i_size);

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store master for a word-addressed memory; sub-word stores use RMW.
// Response 1 (error), 2 (load/word store) or 3 (sub-word store) cycles after accept; no response back-pressure.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData
);

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

  state_t            r_state;
  logic [31:0]       r_addr;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [WORD_W-1:0] r_wdata;
  logic              r_rsp_valid;
  logic              r_rsp_error;
  logic [WORD_W-1:0] r_rsp_rdata;

  logic              w_req_fire;
  logic              w_req_error;
  logic [WORD_W-1:0] w_load_data;
  logic [WORD_W-1:0] w_merged_word;

  assign w_req_fire  = req_valid && req_ready;
  assign w_req_error = (req_size == 2'd3)
                    || (req_size == SZ_HALF && req_addr[0])
                    || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                    || ({1'b0, req_addr} >= ADDR_LIMIT);

  // Strobes are gated by reset so an in-flight access (including an RMW write) dies immediately.
  assign req_ready = !reset && (r_state == IDLE);
  assign memRead   = !reset && (r_state == LOAD  || r_state == RMW_RD);
  assign memWrite  = !reset && (r_state == STORE || r_state == RMW_WR);

  assign memAddress   = {2'b00, r_addr[31:2]};
  assign memWriteData = r_wdata;

  assign rsp_valid = r_rsp_valid;
  assign rsp_error = r_rsp_error;
  assign rsp_rdata = r_rsp_rdata;

  lsu_lane_align u_align (
    .i_rd_word     (memReadData),
    .i_addr_lo     (r_addr[1:0]),
    .i_size        (r_size),
    .i_unsigned    (r_unsigned),
    .i_wdata       (r_wdata),
    .o_load_data   (w_load_data),
    .o_merged_word (w_merged_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_rdata <= '0;
      case (r_state)
        IDLE: begin
          if (w_req_fire) begin
            r_addr     <= req_addr;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_wdata    <= req_wdata;
            if (w_req_error) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_error <= 1'b1;
            end else if (!req_write) begin
              r_state <= LOAD;
            end else if (req_size == SZ_WORD) begin
              r_state <= STORE;
            end else begin
              r_state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          r_rsp_rdata <= w_load_data;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        STORE: begin
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RMW_RD: begin
          // r_wdata is reused to hold the merged word for the write cycle.
          r_wdata <= w_merged_word;
          r_state <= RMW_WR;
        end
        RMW_WR: begin
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 256x32 data memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;

  logic [31:0] mem [256];

  int n_checks = 0;
  int n_errors = 0;
  int both_strobes = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .memAddress   (memAddress),
    .memWriteData (memWriteData),
    .memReadData  (memReadData)
  );

  assign memReadData = memRead ? mem[memAddress[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (memWrite) mem[memAddress[7:0]] <= memWriteData;
  end

  always @(negedge clk) begin
    if (memRead && memWrite) both_strobes++;
  end

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    int rd_cnt;
    int wr_cnt;
    int exp_rd;
    int exp_wr;
    wait_ready();
    req_valid    = 1'b1;
    req_write    = v.wr;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    rd_cnt = 0;
    wr_cnt = 0;
    while (!rsp_valid && lat < 10) begin
      rd_cnt += int'(memRead);
      wr_cnt += int'(memWrite);
      @(posedge clk);
      #1;
      lat++;
    end
    if (v.exp_err) begin
      exp_rd = 0; exp_wr = 0;
    end else if (!v.wr) begin
      exp_rd = 1; exp_wr = 0;
    end else if (v.size == 2'd2) begin
      exp_rd = 0; exp_wr = 1;
    end else begin
      exp_rd = 1; exp_wr = 1;
    end
    check($sformatf("v%0d latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d rsp_error", idx), {31'b0, rsp_error}, {31'b0, v.exp_err});
    check($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
    check($sformatf("v%0d memRead cycles", idx), rd_cnt, exp_rd);
    check($sformatf("v%0d memWrite cycles", idx), wr_cnt, exp_wr);
    if (v.wr && !v.exp_err)
      check($sformatf("v%0d mem word", idx), mem[v.addr[9:2]], v.exp_word);
  endtask

  initial begin
    //          wr    size  uns   addr          wdata         err   rdata         lat  word
    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         2, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 2, 32'h0};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0012, 32'hAAAA_AA55, 1'b0, 32'h0,         3, 32'hDE55_BEEF};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0,         1'b0, 32'hFFFF_FFDE, 2, 32'h0};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0,         1'b0, 32'h0000_00DE, 2, 32'h0};
    vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hFFFF_BEEF, 2, 32'h0};
    vecs[6]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0,         1'b0, 32'h0000_DE55, 2, 32'h0};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0012, 32'hFFFF_1234, 1'b0, 32'h0,         3, 32'h1234_BEEF};
    vecs[8]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0011, 32'h0,         1'b0, 32'hFFFF_FFBE, 2, 32'h0};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0011, 32'h0,         1'b1, 32'h0,         1, 32'h0};
    vecs[10] = '{1'b0, 2'd1, 1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h0,         1, 32'h0};
    vecs[11] = '{1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'h0,         1, 32'h0};
    vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0,         1, 32'h0};
    vecs[13] = '{1'b1, 2'd2, 1'b0, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 32'h0,         2, 32'hCAFE_F00D};
    vecs[14] = '{1'b0, 2'd0, 1'b1, 32'h0000_03FF, 32'h0,         1'b0, 32'h0000_00CA, 2, 32'h0};
    vecs[15] = '{1'b1, 2'd0, 1'b0, 32'h0000_0400, 32'h0000_0011, 1'b1, 32'h0,         1, 32'h0};
    vecs[16] = '{1'b1, 2'd1, 1'b0, 32'h0000_0011, 32'h0000_2222, 1'b1, 32'h0,         1, 32'h0};

    reset = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'd0;
    req_unsigned = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", {31'b0, req_ready}, 32'h0);
    check("reset memRead", {31'b0, memRead}, 32'h0);
    check("reset memWrite", {31'b0, memWrite}, 32'h0);
    check("reset rsp_valid", {31'b0, rsp_valid}, 32'h0);
    reset = 1'b0;
    #1;
    check("post-reset req_ready", {31'b0, req_ready}, 32'h1);
    check("post-reset rsp_rdata", rsp_rdata, 32'h0);
    check("post-reset rsp_error", {31'b0, rsp_error}, 32'h0);

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // Reset during RMW_WR: the merged word must never reach memory.
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size = 2'd0;
    req_addr = 32'h0000_0010;
    req_wdata = 32'h0000_0077;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rmw rd strobe", {31'b0, memRead}, 32'h1);
    @(posedge clk);
    #1;
    check("rmw wr strobe before reset", {31'b0, memWrite}, 32'h1);
    reset = 1'b1;
    #1;
    check("rmw wr gated by reset", {31'b0, memWrite}, 32'h0);
    check("ready low in reset", {31'b0, req_ready}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rmw abort rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rmw abort ready", {31'b0, req_ready}, 32'h1);
    check("rmw abort mem unchanged", mem[4], 32'h1234_BEEF);
    @(posedge clk);
    #1;
    check("rmw abort no late rsp", {31'b0, rsp_valid}, 32'h0);

    // Back-to-back loads with req_valid held high.
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size = 2'd2;
    req_unsigned = 1'b0;
    req_addr = 32'h0000_0010;
    @(posedge clk);
    #1;
    req_size = 2'd0;
    req_unsigned = 1'b1;
    req_addr = 32'h0000_03FF;
    check("b2b ready in LOAD", {31'b0, req_ready}, 32'h0);
    @(posedge clk);
    #1;
    check("b2b ready in RESP", {31'b0, req_ready}, 32'h0);
    check("b2b rsp1 valid", {31'b0, rsp_valid}, 32'h1);
    check("b2b rsp1 rdata", rsp_rdata, 32'h1234_BEEF);
    @(posedge clk);
    #1;
    check("b2b idle ready", {31'b0, req_ready}, 32'h1);
    check("b2b idle rsp_valid", {31'b0, rsp_valid}, 32'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("b2b second load strobe", {31'b0, memRead}, 32'h1);
    @(posedge clk);
    #1;
    check("b2b rsp2 valid", {31'b0, rsp_valid}, 32'h1);
    check("b2b rsp2 rdata", rsp_rdata, 32'h0000_00CA);
    check("b2b rsp2 error", {31'b0, rsp_error}, 32'h0);

    check("memRead/memWrite overlap cycles", both_strobes, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side master for the word-addressed data memory (256 x 32, combinational read gated by memRead, write on posedge clk when memWrite).
- Accepts byte/halfword/word load and store requests from the core via a valid/ready handshake and converts them to word accesses.
- Sub-word stores use read-modify-write.
- Returns sign- or zero-extended load data with a one-cycle response pulse, and flags misaligned or out-of-range requests without touching memory.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in the attached data memory; byte addresses >= MEM_WORDS*4 are out of range.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  core request present
- req_ready  output  1  unit can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_error  output  1  valid with rsp_valid: misaligned, illegal size or out-of-range
- memRead  output  1  to data memory
- memWrite  output  1  to data memory
- memAddress  output  32  word index = req_addr[31:2]
- memWriteData  output  32  word to write
- memReadData  input  32  word from memory, combinational

Behaviour:
- Synchronous active-high reset: one clock, one synchronous active-high reset. Reset takes priority over everything.
- State on reset: state = IDLE; rsp_valid, rsp_error, memRead and memWrite are 0; rsp_rdata = 0.
- Outputs while reset is high: req_ready = 0, memWrite = 0 and memRead = 0, even mid-operation. An in-flight access is aborted, including a pending RMW write, and no response is produced.
- Request capture: a request is accepted on a rising edge with req_valid && req_ready. req_ready = 1 only in IDLE. The address, size, unsigned flag and wdata are captured into registers.
- Error check at acceptance, with no memory access on error:
  - size 3;
  - halfword with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr >= MEM_WORDS*4.
  On error go to RESP with rsp_error = 1.
- Byte order is little-endian: lane k = bits [8k+7:8k] at addr[1:0] = k. A halfword uses lanes {addr[1]*2+1, addr[1]*2}.
- States:
  - IDLE: idle; accept a request (see above).
  - LOAD: memRead = 1, memAddress = word index. On the edge, extract the lane, extend per size/unsigned, and register the result. Next state RESP.
  - STORE (word): memWrite = 1, memWriteData = wdata. Next state RESP.
  - RMW_RD (byte/half store): memRead = 1; the edge captures the old word. Next state RMW_WR.
  - RMW_WR: memWrite = 1, memWriteData = old word with the target lanes replaced by the low bits of wdata. Next state RESP.
  - RESP: rsp_valid = 1 for exactly one cycle. Next state IDLE.
- Latency, counted from the acceptance edge: rsp_valid is high in the 2nd cycle for load and word store, the 3rd cycle for sub-word store, and the 1st cycle for an error.
- Responses have no back-pressure. The next request can be accepted at the end of the cycle after RESP (IDLE).
- memRead and memWrite are never both 1. Both are 0 in IDLE and RESP. memAddress and memWriteData are don't-care when their strobe is low.
- The maximum legal address MEM_WORDS*4-1 maps to word MEM_WORDS-1; there is no wrap-around.

Decomposition:
- lsu_pkg holds the size codes (SZ_BYTE, SZ_HALF, SZ_WORD), the state enum (IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP) and the word width constant.
- One combinational sub-module, lsu_lane_align, contains two functions:
  - load extract/extend: word, addr[1:0], size, unsigned -> 32-bit result;
  - store merge: old word, wdata, addr[1:0], size -> new word.

Test Plan:
- Word store then load: store 0xDEADBEEF at addr 0x10, then load word at 0x10 -> memory word 4 = 0xDEADBEEF; rsp_rdata = 0xDEADBEEF 2 cycles after load acceptance; rsp_error = 0.
- Sub-word RMW: with word 4 = 0xDEADBEEF, byte store 0x55 at 0x12 -> word 4 = 0xDE55BEEF; exactly one memRead cycle then one memWrite cycle; rsp_valid in the 3rd cycle.
- Extension: load byte signed at 0x13 -> 0xFFFFFFDE; unsigned -> 0x000000DE; halfword signed at 0x10 -> 0xFFFFBEEF.
- Errors: load word at 0x11, halfword at 0x13, size 3, and word load at 0x400 (MEM_WORDS = 256) -> rsp_valid one cycle after acceptance with rsp_error = 1, rsp_rdata = 0; memRead and memWrite never asserted.
- Reset mid-RMW: assert reset during the RMW_WR cycle -> memWrite = 0, memory unchanged, no rsp_valid; req_ready = 1 on the first cycle after reset falls.
- Back-to-back: req_valid held high with two loads -> second accepted only in IDLE after RESP; req_ready = 0 in LOAD and RESP; both responses correct and in order.
